// File: rtl/uart_rx_deframer_pkg.sv
// uart_rx_deframer_pkg: shared FSM states, word-layout constants and the 3-sample vote
package uart_rx_deframer_pkg;
  localparam int DATA7 = 7;
  localparam int DATA8 = 8;
  localparam int FRAME_W = 9;
  localparam int OVERSAMPLE_DEF = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_deframer_if.sv
// uart_rx_deframer_if: serial line, mode switches and frame output bundle
interface uart_rx_deframer_if;
  import uart_rx_deframer_pkg::*;
  logic rx, SW0, SW1, data_valid, frame_err, busy;
  logic [FRAME_W-1:0] data_out;
  modport master(input rx, SW0, SW1, output data_out, data_valid, frame_err, busy);
  modport slave(output rx, SW0, SW1, input data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider, one-clock tick every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    if (!rst || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampling UART receiver producing raw 9-bit frame words
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115_200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input logic clk,
  input logic rst,
  uart_rx_deframer_if.master bus
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int M = OVERSAMPLE / 2 - 1;
  localparam int PW = $clog2(OVERSAMPLE);
  state_t state, state_n;
  logic tick, rx_m, rx_s, armed, s0, s1, par_l, n8_l;
  logic start_det, dec, bit_v, last_bit, strobe;
  logic [PW-1:0] phase, ph_nxt;
  logic [2:0] bit_cnt;
  logic [FRAME_W-1:0] sh;

  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

  // phase counts ticks since start detect; a bit decision lands on tick M+1 of each bit
  assign ph_nxt = (phase == PW'(OVERSAMPLE - 1)) ? '0 : phase + 1'b1;
  assign start_det = state == IDLE && armed && !rx_s && tick;
  assign dec = state != IDLE && tick && ph_nxt == PW'(M + 1);
  assign bit_v = maj3(s0, s1, rx_s);
  assign last_bit = bit_cnt == (n8_l ? 3'(DATA8 - 1) : 3'(DATA7 - 1));

  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_det ? START : IDLE;
      START:   state_n = dec ? (bit_v ? IDLE : DATA) : START;
      DATA:    state_n = dec && last_bit ? (par_l ? PARITY : STOP) : DATA;
      PARITY:  state_n = dec ? STOP : PARITY;
      STOP:    state_n = dec ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = state != IDLE;
    strobe = state == STOP && dec;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      armed <= 1'b0;
      phase <= '0;
      bit_cnt <= '0;
      s0 <= 1'b0;
      s1 <= 1'b0;
      par_l <= 1'b0;
      n8_l <= 1'b0;
      sh <= '0;
      bus.data_out <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
      // a low stop bit leaves the line low, so re-arm only once it is seen high again
      armed <= state == IDLE && (armed || rx_s);
      bus.data_valid <= strobe;
      if (start_det) begin
        phase <= '0;
        bit_cnt <= '0;
        sh <= '0;
        par_l <= bus.SW0;
        n8_l <= bus.SW1;
      end else if (tick && state != IDLE) begin
        phase <= ph_nxt;
        if (ph_nxt == PW'(M - 1)) s0 <= rx_s;
        if (ph_nxt == PW'(M)) s1 <= rx_s;
      end
      if (dec && state == DATA) begin
        sh[bit_cnt] <= bit_v;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (dec && state == PARITY) sh[n8_l ? DATA8 : DATA7] <= bit_v;
      if (strobe) begin
        bus.data_out <= sh;
        bus.frame_err <= !bit_v;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed and random frames checked against a frame-level model
module tb_uart_rx_deframer;
  localparam int BIT = 160;
  typedef struct {
    logic [8:0] word;
    logic err;
    longint lo;
    longint hi;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  uart_rx_deframer_if bus();
  uart_rx_deframer #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;

  exp_t q[$];
  exp_t e;
  int vectors = 0, miscompares = 0, n_strobe = 0, s0 = 0;
  longint cyc = 0;
  logic r_edge;
  logic [8:0] held_word = '0, last_word = '0;
  logic held_err = 1'b0, last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // frame word from the line-level description: masked data, parity bit just above it
  function automatic logic [8:0] exp_word(input logic [7:0] d, input bit n8, input bit pe, input bit pb);
    int n = n8 ? 8 : 7;
    int w = int'(d) % (1 << n);
    if (pe && pb) w += 1 << n;
    return 9'(w);
  endfunction

  always @(posedge clk) begin
    r_edge = rst;
    cyc++;
    #1;
    if (!r_edge) begin
      held_word = '0;
      held_err = 1'b0;
      chk("rst_valid", 32'(bus.data_valid), 0);
      chk("rst_word", 32'(bus.data_out), 0);
      chk("rst_err", 32'(bus.frame_err), 0);
      chk("rst_busy", 32'(bus.busy), 0);
    end else if (bus.data_valid) begin
      n_strobe++;
      last_word = bus.data_out;
      last_err = bus.frame_err;
      chk("strobe_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("word", 32'(bus.data_out), 32'(e.word));
        chk("frame_err", 32'(bus.frame_err), 32'(e.err));
        chk("strobe_in_stop", 32'(cyc > e.lo && cyc < e.hi), 1);
        held_word = e.word;
        held_err = e.err;
      end
    end else begin
      chk("hold_word", 32'(bus.data_out), 32'(held_word));
      chk("hold_err", 32'(bus.frame_err), 32'(held_err));
    end
  end

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit n8, input bit pe, input bit pb, input bit sb,
                      input int rst_bit = -1);
    int n = n8 ? 8 : 7;
    bus.SW0 = pe;
    bus.SW1 = n8;
    bus.rx = 1'b0;
    repeat (BIT) @(negedge clk);
    bus.SW0 = 1'($urandom);
    bus.SW1 = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      bus.rx = d[i];
      if (i == rst_bit) begin
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (BIT / 2 - 1) @(negedge clk);
      end else repeat (BIT) @(negedge clk);
    end
    if (pe) begin
      bus.rx = pb;
      repeat (BIT) @(negedge clk);
    end
    bus.rx = sb;
    if (rst_bit < 0) q.push_back('{word: exp_word(d, n8, pe, pb), err: !sb, lo: cyc, hi: cyc + BIT});
    repeat (BIT) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx = 1'b1;
    bus.SW0 = 1'b0;
    bus.SW1 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(40);
    chk("busy_idle", 32'(bus.busy), 0);
    s0 = n_strobe;
    send(8'h55, 1, 0, 0, 1);
    chk("n_55", 32'(n_strobe - s0), 1);
    chk("lit_55", 32'(last_word), 32'h055);
    chk("lit_55_err", 32'(last_err), 0);
    idle(23);
    send(8'h43, 0, 1, 1, 1);
    chk("lit_43_7e1", 32'(last_word), 32'h0C3);
    idle(7);
    send(8'hA7, 1, 1, 1, 1);
    chk("lit_a7_p1", 32'(last_word), 32'h1A7);
    idle(11);
    send(8'hA7, 1, 1, 0, 1);
    chk("lit_a7_p0", 32'(last_word), 32'h0A7);
    idle(5);
    send(8'h3C, 1, 0, 0, 0);
    chk("lit_3c_bad", 32'(last_word), 32'h03C);
    chk("lit_3c_bad_err", 32'(last_err), 1);
    idle(2 * BIT);
    send(8'h3C, 1, 0, 0, 1);
    chk("lit_3c_good_err", 32'(last_err), 0);
    idle(31);
    s0 = n_strobe;
    bus.rx = 1'b0;
    repeat (50) @(negedge clk);
    bus.rx = 1'b1;
    repeat (BIT - 50) @(negedge clk);
    chk("glitch_busy", 32'(bus.busy), 0);
    chk("glitch_no_strobe", 32'(n_strobe - s0), 0);
    idle(17);
    send(8'h12, 1, 0, 0, 1);
    chk("lit_12", 32'(last_word), 32'h012);
    idle(13);
    s0 = n_strobe;
    send(8'hF8, 1, 0, 0, 1, 3);
    chk("abort_no_strobe", 32'(n_strobe - s0), 0);
    idle(19);
    send(8'h81, 1, 0, 0, 1);
    chk("lit_81", 32'(last_word), 32'h081);
    for (int k = 0; k < 18; k++) begin
      idle($urandom_range(5, 200));
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5) != 0);
    end
    idle(BIT);
    chk("queue_empty", 32'(q.size()), 0);
    chk("busy_end", 32'(bus.busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
